// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: multi-cycle unsigned magnitude comparator.
// A single 2-bit comparator slice walks both operands from the MSB digit to
// the LSB digit, one digit per clock, behind a start/busy/done handshake.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           comparison request, sampled only while idle
//   a, b            WIDTH-bit unsigned operands, captured on the accepting edge
//   busy            high while digits are being examined
//   done            one-cycle pulse when the result flags update
//   alb, aeb, agb   registered A<B, A==B, A>B
module seq_mag_comparator #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             alb,
   output logic             aeb,
   output logic             agb
);

   localparam int unsigned D  = WIDTH / 2;
   localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dec_q, dec_d;
   logic             plt_q, plt_d;
   logic             pgt_q, pgt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [2:0]       flags_q, flags_d;   // {alb, aeb, agb}

   // Shared 2-bit slice on the current most-significant digit
   logic [1:0] x, y;
   logic       lt, gt, eq;
   logic       dec_n, lt_n, gt_n;

   always_comb begin
      x  = sa_q[WIDTH-1 -: 2];
      y  = sb_q[WIDTH-1 -: 2];
      lt = (~x[1] & ~x[0] & y[0]) | (~x[1] & y[1]) | (y[1] & y[0] & ~x[0]);
      gt = (x[1] & x[0] & ~y[0]) | (x[1] & ~y[1]) | (~y[1] & ~y[0] & x[0]);
      eq = ~lt & ~gt;
      // The first unequal digit wins; lower digits cannot override it
      dec_n = dec_q | ~eq;
      lt_n  = dec_q ? plt_q : lt;
      gt_n  = dec_q ? pgt_q : gt;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      plt_d   = plt_q;
      pgt_d   = pgt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      flags_d = flags_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               cnt_d   = CW'(D - 1);
               dec_d   = 1'b0;
               plt_d   = 1'b0;
               pgt_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            dec_d = dec_n;
            plt_d = lt_n;
            pgt_d = gt_n;
            if (((EARLY_EXIT != 0) && !eq) || (cnt_q == CW'(0))) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               flags_d = dec_n ? {lt_n, 1'b0, gt_n} : 3'b010;
            end else begin
               busy_d = 1'b1;
               sa_d   = sa_q << 2;
               sb_d   = sb_q << 2;
               cnt_d  = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
         plt_q   <= 1'b0;
         pgt_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         flags_q <= 3'b000;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         plt_q   <= plt_d;
         pgt_q   <= pgt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         flags_q <= flags_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign alb  = flags_q[2];
   assign aeb  = flags_q[1];
   assign agb  = flags_q[0];

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed self-checking bench for seq_mag_comparator.
// Three instances: WIDTH=8 early-exit, WIDTH=8 full-scan, WIDTH=2 early-exit.
module tb_seq_mag_comparator;

   logic       clk;
   logic       rst;
   logic [2:0] start_v;
   logic [7:0] a_v [3];
   logic [7:0] b_v [3];
   logic [2:0] busy_v, done_v, alb_v, aeb_v, agb_v;

   int n_checks = 0;
   int n_pass   = 0;

   seq_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1)) u_dut_ee (
      .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .alb(alb_v[0]), .aeb(aeb_v[0]), .agb(agb_v[0]));

   seq_mag_comparator #(.WIDTH(8), .EARLY_EXIT(0)) u_dut_full (
      .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .alb(alb_v[1]), .aeb(aeb_v[1]), .agb(agb_v[1]));

   seq_mag_comparator #(.WIDTH(2), .EARLY_EXIT(1)) u_dut_w2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][1:0]), .b(b_v[2][1:0]),
      .busy(busy_v[2]), .done(done_v[2]), .alb(alb_v[2]), .aeb(aeb_v[2]), .agb(agb_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [2:0] flags_of(input int sel);
      return {alb_v[sel], aeb_v[sel], agb_v[sel]};
   endfunction

   // Waits for done (bounded); returns cycles after E0 and the count of busy samples
   task automatic wait_done(input int sel, output int cyc, output int nbusy);
      cyc   = 0;
      nbusy = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (done_v[sel]) break;
         if (busy_v[sel]) nbusy++;
      end
   endtask

   // One comparison: start pulsed for a single edge, then result/latency checked
   task automatic run_cmp(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] exp_flags, input int exp_d, input string tag);
      int cyc, nbusy;
      @(negedge clk);
      a_v[sel] = a; b_v[sel] = b; start_v[sel] = 1'b1;
      @(posedge clk); #1;
      start_v[sel] = 1'b0;
      nbusy = 0;
      if (exp_d > 0) check({tag, " busy@E0+"}, 32'(busy_v[sel]), 32'd1);
      wait_done(sel, cyc, nbusy);
      check({tag, " latency"}, 32'(cyc), 32'(exp_d));
      check({tag, " busy_cycles"}, 32'(nbusy + 1), 32'(exp_d));
      check({tag, " flags"}, 32'(flags_of(sel)), 32'(exp_flags));
      check({tag, " busy@done"}, 32'(busy_v[sel]), 32'd0);
      @(posedge clk); #1;
      check({tag, " done_pulse"}, 32'(done_v[sel]), 32'd0);
      check({tag, " flags_hold"}, 32'(flags_of(sel)), 32'(exp_flags));
   endtask

   initial begin
      int cyc, nbusy, ndone;
      logic [7:0] ta, tb;

      rst = 1'b1;
      start_v = 3'b000;
      for (int i = 0; i < 3; i++) begin a_v[i] = 8'h00; b_v[i] = 8'h00; end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", 32'({busy_v, done_v, alb_v, aeb_v, agb_v}), 32'd0);
      rst = 1'b0;

      // Early-exit instance
      run_cmp(0, 8'h5A, 8'h5A, 3'b010, 4, "ee_5A_5A");
      run_cmp(0, 8'h80, 8'h7F, 3'b001, 1, "ee_80_7F");
      run_cmp(0, 8'h12, 8'h13, 3'b100, 4, "ee_12_13");
      run_cmp(0, 8'h34, 8'h3C, 3'b100, 3, "ee_34_3C");
      run_cmp(0, 8'hFF, 8'h00, 3'b001, 1, "ee_FF_00");

      // Full-scan instance: lower digits must not override the first decision
      run_cmp(1, 8'h80, 8'h7F, 3'b001, 4, "full_80_7F");
      run_cmp(1, 8'h40, 8'h3F, 3'b001, 4, "full_40_3F");
      run_cmp(1, 8'h00, 8'hFF, 3'b100, 4, "full_00_FF");
      run_cmp(1, 8'h0F, 8'h0C, 3'b001, 4, "full_0F_0C");
      run_cmp(1, 8'hA5, 8'hA5, 3'b010, 4, "full_A5_A5");

      // start held high, operands scrambled during RUN
      @(negedge clk);
      a_v[0] = 8'h12; b_v[0] = 8'h13; start_v[0] = 1'b1;
      @(posedge clk); #1;
      check("hold busy@E0+", 32'(busy_v[0]), 32'd1);
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         a_v[0] = 8'hFF - 8'(i); b_v[0] = 8'(i);
         @(posedge clk); #1;
         cyc++;
         if (done_v[0]) break;
      end
      check("hold latency", 32'(cyc), 32'd4);
      check("hold flags", 32'(flags_of(0)), 32'b100);
      @(negedge clk);
      a_v[0] = 8'h5A; b_v[0] = 8'h5A;
      @(posedge clk); #1;
      check("hold no_accept_in_done", 32'(busy_v[0]), 32'd0);
      wait_done(0, cyc, nbusy);
      check("hold second flags", 32'(flags_of(0)), 32'b010);
      check("hold second single_accept", 32'(done_v[0]), 32'd1);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (3) @(posedge clk);

      // Asynchronous reset mid-clock with flags set
      @(negedge clk); #2;
      rst = 1'b1; #1;
      check("async_reset", 32'({busy_v, done_v, alb_v, aeb_v, agb_v}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset at E2 of a running comparison
      run_cmp(0, 8'h12, 8'h13, 3'b100, 4, "pre_abort");
      @(negedge clk);
      a_v[0] = 8'h5A; b_v[0] = 8'h5A; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1; #1;
      check("abort flags", 32'({busy_v[0], done_v[0], flags_of(0)}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done_v[0] || busy_v[0]) ndone++;
      end
      check("abort no_done", 32'(ndone), 32'd0);
      run_cmp(0, 8'h80, 8'h7F, 3'b001, 1, "post_abort");

      // WIDTH=2 exhaustive
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            ta = 8'(i); tb = 8'(j);
            run_cmp(2, ta, tb, {ta < tb, ta == tb, ta > tb}, 1,
                    $sformatf("w2_%0d_%0d", i, j));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
